// File: rtl/relu_stream_ctrl.sv
// Job sequencer for the streaming ReLU/ReLU6 activation stage: latches a job
// configuration on start, streams LANES signed lanes per beat with a one-cycle output register.
module relu_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                     Clk_i,
  input  logic                     Rst_n_i,
  input  logic                     Start_i,
  input  logic [CNT_W-1:0]         Len_i,
  input  logic                     ReLUMod_i,
  input  logic [3:0]               Data_Bp_i,
  input  logic [3:0]               Result_Bp_i,
  input  logic                     In_Valid_i,
  output logic                     In_Ready_o,
  input  logic [WIDTH*LANES-1:0]   In_Data_i,
  output logic                     Out_Valid_o,
  input  logic                     Out_Ready_i,
  output logic [WIDTH*LANES-1:0]   Out_Data_o,
  output logic                     Busy_o,
  output logic                     Done_o
);

  localparam int XW = WIDTH + 16;
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
  logic                     mode_q, mode_d;
  logic [3:0]               dbp_q, dbp_d;
  logic [3:0]               rbp_q, rbp_d;
  logic                     out_vld_q, out_vld_d;
  logic [WIDTH*LANES-1:0]   out_data_q, out_data_d;
  logic [WIDTH*LANES-1:0]   lane_res;
  logic                     in_acc, out_acc;

  // Binary-point alignment of a non-negative lane; left shifts saturate to the positive maximum.
  function automatic logic [WIDTH-1:0] sat_align(input logic [WIDTH-1:0] v,
                                                 input logic [3:0] dbp,
                                                 input logic [3:0] rbp);
    logic signed [4:0] d;
    logic [4:0]        nd;
    logic [XW-1:0]     wide;
    d    = $signed({1'b0, rbp}) - $signed({1'b0, dbp});
    nd   = 5'(-d);
    wide = {16'd0, v} << d[3:0];
    if (d > 0)
      sat_align = (|wide[XW-1:WIDTH-1]) ? POS_MAX : wide[WIDTH-1:0];
    else if (d < 0)
      sat_align = v >> nd;
    else
      sat_align = v;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_relu6(input logic [WIDTH-1:0] v,
                                                   input logic [3:0] rbp);
    logic [XW-1:0]    lim_w;
    logic [WIDTH-1:0] lim;
    lim_w = XW'(6) << rbp;
    lim   = (lim_w > XW'(POS_MAX)) ? POS_MAX : lim_w[WIDTH-1:0];
    clamp_relu6 = (v > lim) ? lim : v;
  endfunction

  function automatic logic [WIDTH-1:0] lane_fn(input logic signed [WIDTH-1:0] x,
                                               input logic mode,
                                               input logic [3:0] dbp,
                                               input logic [3:0] rbp);
    logic [WIDTH-1:0] v;
    v = (x < 0) ? '0 : $unsigned(x);
    v = sat_align(v, dbp, rbp);
    if (mode)
      v = clamp_relu6(v, rbp);
    lane_fn = v;
  endfunction

  assign In_Ready_o  = (state_q == RUN) && (in_cnt_q < len_q) && (!out_vld_q || Out_Ready_i);
  assign in_acc      = In_Valid_i && In_Ready_o;
  assign out_acc     = out_vld_q && Out_Ready_i;
  assign Out_Valid_o = out_vld_q;
  assign Out_Data_o  = out_data_q;
  assign Busy_o      = (state_q != IDLE);
  assign Done_o      = (state_q == DONE);

  always_comb begin
    lane_res = '0;
    for (int k = 0; k < LANES; k++)
      lane_res[k*WIDTH +: WIDTH] = lane_fn($signed(In_Data_i[k*WIDTH +: WIDTH]),
                                           mode_q, dbp_q, rbp_q);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    mode_d     = mode_q;
    dbp_d      = dbp_q;
    rbp_d      = rbp_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;

    if (in_acc) begin
      in_cnt_d   = in_cnt_q + CNT_W'(1);
      out_vld_d  = 1'b1;
      out_data_d = lane_res;
    end else if (out_acc) begin
      out_vld_d  = 1'b0;
    end
    if (out_acc)
      out_cnt_d = out_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          len_d     = Len_i;
          mode_d    = ReLUMod_i;
          dbp_d     = Data_Bp_i;
          rbp_d     = Result_Bp_i;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (Len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_cnt_d == len_q)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (out_acc && (out_cnt_q == len_q - CNT_W'(1)))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      mode_q     <= 1'b0;
      dbp_q      <= '0;
      rbp_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      dbp_q      <= dbp_d;
      rbp_q      <= rbp_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Bench for relu_stream_ctrl: table of single-beat jobs plus scripted multi-cycle
// sequences; a negedge monitor scores every output beat against a queue of expected words.
module tb_relu_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int DW    = WIDTH * LANES;

  logic             Clk_i = 1'b0;
  logic             Rst_n_i;
  logic             Start_i;
  logic [CNT_W-1:0] Len_i;
  logic             ReLUMod_i;
  logic [3:0]       Data_Bp_i;
  logic [3:0]       Result_Bp_i;
  logic             In_Valid_i;
  logic             In_Ready_o;
  logic [DW-1:0]    In_Data_i;
  logic             Out_Valid_o;
  logic             Out_Ready_i;
  logic [DW-1:0]    Out_Data_o;
  logic             Busy_o;
  logic             Done_o;

  relu_stream_ctrl #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .Clk_i(Clk_i), .Rst_n_i(Rst_n_i), .Start_i(Start_i), .Len_i(Len_i),
    .ReLUMod_i(ReLUMod_i), .Data_Bp_i(Data_Bp_i), .Result_Bp_i(Result_Bp_i),
    .In_Valid_i(In_Valid_i), .In_Ready_o(In_Ready_o), .In_Data_i(In_Data_i),
    .Out_Valid_o(Out_Valid_o), .Out_Ready_i(Out_Ready_i), .Out_Data_o(Out_Data_o),
    .Busy_o(Busy_o), .Done_o(Done_o)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct {
    logic [DW-1:0] din;
    logic          mode;
    logic [3:0]    dbp;
    logic [3:0]    rbp;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tv[8];
  logic [DW-1:0] bp_in[4];
  logic [DW-1:0] bp_exp[4];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp;
  int errors = 0, checks = 0;
  int in_acc_n = 0, out_n = 0, done_n = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Handshakes are decided by values stable at the falling edge.
  always @(negedge Clk_i) begin
    if (Rst_n_i) begin
      if (Out_Valid_o && Out_Ready_i) begin
        out_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got beat %h, required no beat", Out_Data_o);
        end else begin
          check("out_data", Out_Data_o, exp_q.pop_front());
        end
      end
      if (In_Valid_i && In_Ready_o) begin
        exp_q.push_back(cur_exp);
        in_acc_n++;
      end
      if (Done_o) done_n++;
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] len, input logic mode,
                           input logic [3:0] dbp, input logic [3:0] rbp);
    Start_i = 1'b1; Len_i = len; ReLUMod_i = mode; Data_Bp_i = dbp; Result_Bp_i = rbp;
    tick();
    Start_i = 1'b0; Len_i = ~len; ReLUMod_i = ~mode;
    Data_Bp_i = dbp ^ 4'd3; Result_Bp_i = rbp ^ 4'd5;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] e);
    bit got;
    got = 1'b0;
    In_Valid_i = 1'b1; In_Data_i = d; cur_exp = e;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk_i);
      if (In_Ready_o) got = 1'b1;
    end
    tick();
    In_Valid_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL in_accept: beat %h not accepted in 50 cycles, required acceptance", d);
    end
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(negedge Clk_i);
      cyc++;
      if (Done_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_seen: no Done_o in 200 cycles, required a pulse");
    end
    check("busy_at_done", Busy_o, 1);
    @(negedge Clk_i);
    check("done_one_cycle", Done_o, 0);
    check("busy_after_done", Busy_o, 0);
    check("queue_drained", exp_q.size(), 0);
    tick();
  endtask

  task automatic bp_sender();
    for (int k = 0; k < 4; k++) send_beat(bp_in[k], bp_exp[k]);
    In_Valid_i = 1'b1; In_Data_i = 32'h11111111; cur_exp = 32'hDEADBEEF;
  endtask

  task automatic bp_ctrl();
    logic [DW-1:0] held;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk_i);
      if (Out_Valid_o) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first_out: no Out_Valid_o in 20 cycles, required one");
    end
    tick();
    Out_Ready_i = 1'b0;
    @(negedge Clk_i);
    held = Out_Data_o;
    check("bp_valid_held", Out_Valid_o, 1);
    check("bp_in_ready_low", In_Ready_o, 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge Clk_i);
      check("bp_valid_held", Out_Valid_o, 1);
      check("bp_data_held", Out_Data_o, held);
      check("bp_in_ready_low", In_Ready_o, 0);
    end
    tick();
    Out_Ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, d0, a0, o0;

    tv[0] = '{32'h807FF010, 1'b0, 4'd4, 4'd4, 32'h007F0010};
    tv[1] = '{32'h0040FF01, 1'b0, 4'd4, 4'd4, 32'h00400001};
    tv[2] = '{32'h10FB3005, 1'b0, 4'd2, 4'd4, 32'h40007F14};
    tv[3] = '{32'h07087F1F, 1'b0, 4'd4, 4'd1, 32'h00010F03};
    tv[4] = '{32'hFF605070, 1'b1, 4'd4, 4'd4, 32'h00605060};
    tv[5] = '{32'h7E40C07F, 1'b1, 4'd5, 4'd5, 32'h7E40007F};
    tv[6] = '{32'h80050607, 1'b1, 4'd0, 4'd0, 32'h00050606};
    tv[7] = '{32'hFF011008, 1'b1, 4'd0, 4'd3, 32'h00083030};
    bp_in  = '{32'h04030201, 32'h807F08F0, 32'h0C0B0A09, 32'h01FF027E};
    bp_exp = '{32'h04030201, 32'h007F0800, 32'h0C0B0A09, 32'h0100027E};

    Rst_n_i = 1'b0; Start_i = 1'b0; Len_i = '0; ReLUMod_i = 1'b0;
    Data_Bp_i = '0; Result_Bp_i = '0; In_Valid_i = 1'b0; In_Data_i = '0;
    Out_Ready_i = 1'b1; cur_exp = '0;
    repeat (2) @(negedge Clk_i);
    check("rst_in_ready", In_Ready_o, 0);
    check("rst_out_valid", Out_Valid_o, 0);
    check("rst_out_data", Out_Data_o, 0);
    check("rst_busy", Busy_o, 0);
    check("rst_done", Done_o, 0);
    tick();
    Rst_n_i = 1'b1;
    tick();

    // Two-beat plain ReLU job at full rate; a stray start during RUN must be ignored.
    d0 = done_n;
    start_job(16'd2, 1'b0, 4'd4, 4'd4);
    Start_i = 1'b1; Len_i = 16'd0;
    send_beat(tv[0].din, tv[0].exp);
    Start_i = 1'b0;
    send_beat(tv[1].din, tv[1].exp);
    wait_done(cyc);
    check("len2_done_latency", cyc, 2);
    check("len2_done_count", done_n - d0, 1);

    for (int i = 0; i < 8; i++) begin
      start_job(16'd1, tv[i].mode, tv[i].dbp, tv[i].rbp);
      send_beat(tv[i].din, tv[i].exp);
      wait_done(cyc);
    end

    // Backpressure mid-stream, with input held valid past the last beat.
    a0 = in_acc_n; o0 = out_n;
    start_job(16'd4, 1'b0, 4'd4, 4'd4);
    fork
      bp_sender();
      bp_ctrl();
    join
    wait_done(cyc);
    In_Valid_i = 1'b0;
    check("bp_inputs_accepted", in_acc_n - a0, 4);
    check("bp_outputs_seen", out_n - o0, 4);

    // Zero-length job; a start during the DONE cycle must be ignored.
    d0 = done_n; a0 = in_acc_n;
    In_Valid_i = 1'b1; In_Data_i = 32'h22222222; cur_exp = 32'hDEADBEEF;
    start_job(16'd0, 1'b0, 4'd4, 4'd4);
    Start_i = 1'b1; Len_i = 16'd3;
    @(negedge Clk_i);
    check("len0_done", Done_o, 1);
    check("len0_busy", Busy_o, 1);
    check("len0_in_ready", In_Ready_o, 0);
    tick();
    Start_i = 1'b0;
    @(negedge Clk_i);
    check("len0_done_after", Done_o, 0);
    check("len0_busy_after", Busy_o, 0);
    check("len0_in_ready_after", In_Ready_o, 0);
    tick();
    In_Valid_i = 1'b0;
    check("len0_no_inputs", in_acc_n - a0, 0);
    check("len0_done_count", done_n - d0, 1);

    // Asynchronous reset after two of five beats, then a fresh one-beat job.
    start_job(16'd5, 1'b0, 4'd4, 4'd4);
    send_beat(tv[0].din, tv[0].exp);
    send_beat(tv[1].din, tv[1].exp);
    d0 = done_n;
    #2;
    Rst_n_i = 1'b0;
    #1;
    check("abort_out_valid", Out_Valid_o, 0);
    check("abort_out_data", Out_Data_o, 0);
    check("abort_busy", Busy_o, 0);
    check("abort_in_ready", In_Ready_o, 0);
    exp_q.delete();
    repeat (2) @(negedge Clk_i);
    tick();
    Rst_n_i = 1'b1;
    repeat (3) tick();
    check("abort_no_done", done_n - d0, 0);
    check("abort_idle", Busy_o, 0);
    start_job(16'd1, 1'b1, 4'd4, 4'd4);
    send_beat(tv[4].din, tv[4].exp);
    wait_done(cyc);
    check("post_abort_done_count", done_n - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
